// File: rtl/vga_text_console_param.sv
// Text console: character stream in, COLS x ROWS cell buffer, RGB332 pixels out.
// Scrolling rotates a ring-buffer row offset (top_row) instead of moving cell data.
module vga_text_console_param #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter int          FONT_W       = 8,
  parameter int          FONT_H       = 16,
  parameter logic [7:0]  DEF_ATTR     = 8'h0A,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       frame_tick,
  input  logic       char_valid,
  input  logic [6:0] char_data,
  output logic       char_ready,
  input  logic       attr_we,
  input  logic [7:0] attr_data,
  input  logic       cursor_en,
  output logic [7:0] text_rgb,
  output logic       busy
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);
  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [10:0] X_LIM = 11'(COLS * FONT_W);
  localparam logic [10:0] Y_LIM = 11'(ROWS * FONT_H);

  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;

  function automatic logic [YW-1:0] wrap_row(input logic [YW-1:0] l, input logic [YW-1:0] t);
    logic [YW:0] s;
    s = {1'b0, l} + {1'b0, t};
    if (s >= (YW+1)'(ROWS)) s = s - (YW+1)'(ROWS);
    return s[YW-1:0];
  endfunction

  function automatic logic [AW-1:0] row_base(input logic [YW-1:0] r);
    return AW'(r) * AW'(COLS);
  endfunction

  function automatic logic [7:0] pal(input logic [3:0] c);
    logic [2:0] lvl;
    lvl = c[3] ? 3'd7 : 3'd4;
    return {c[2] ? lvl : 3'd0, c[1] ? lvl : 3'd0, c[0] ? (c[3] ? 2'd3 : 2'd2) : 2'd0};
  endfunction

  // 8x8 glyphs, each row shown twice to fill the 16-line cell; lowercase folds to uppercase
  function automatic logic [63:0] glyph(input logic [6:0] ch);
    logic [6:0] u;
    u = (ch >= 7'h61 && ch <= 7'h7A) ? ch - 7'h20 : ch;
    case (u)
      7'h20: return 64'h0000000000000000;
      7'h41: return 64'h183C66667E666600;
      7'h42: return 64'h7C66667C66667C00;
      7'h43: return 64'h3C66606060663C00;
      7'h44: return 64'h786C6666666C7800;
      7'h45: return 64'h7E60607860607E00;
      7'h46: return 64'h7E60607860606000;
      7'h47: return 64'h3C66606E66663C00;
      7'h48: return 64'h6666667E66666600;
      7'h49: return 64'h3C18181818183C00;
      7'h4A: return 64'h1E0C0C0C0C6C3800;
      7'h4B: return 64'h666C7870786C6600;
      7'h4C: return 64'h6060606060607E00;
      7'h4D: return 64'h63777F6B63636300;
      7'h4E: return 64'h66767E7E6E666600;
      7'h4F: return 64'h3C66666666663C00;
      7'h50: return 64'h7C66667C60606000;
      7'h51: return 64'h3C666666663C0E00;
      7'h52: return 64'h7C66667C786C6600;
      7'h53: return 64'h3C66603C06663C00;
      7'h54: return 64'h7E18181818181800;
      7'h55: return 64'h6666666666663C00;
      7'h56: return 64'h66666666663C1800;
      7'h57: return 64'h6363636B7F776300;
      7'h58: return 64'h66663C183C666600;
      7'h59: return 64'h6666663C18181800;
      7'h5A: return 64'h7E060C1830607E00;
      default: return 64'h7E424242424242_7E;
    endcase
  endfunction

  state_t          state, state_nxt;
  logic [XW-1:0]   cx, cx_nxt;
  logic [YW-1:0]   cy, cy_nxt, top_row, top_nxt;
  logic [AW-1:0]   clr_cnt, cnt_nxt;
  logic [7:0]      attr, clr_attr, cattr_nxt;
  logic            wr_en, newline;
  logic [AW-1:0]   wr_addr;
  logic [14:0]     wr_data;
  logic [7:0]      tab_pos;
  logic [14:0]     mem [DEPTH];
  logic [14:0]     cell_q;
  logic [BW-1:0]   blink_cnt;
  logic            blink_on;

  assign char_ready = (state == IDLE);
  assign busy       = ~char_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= CLR_ALL;
      cx       <= '0;
      cy       <= '0;
      top_row  <= '0;
      clr_cnt  <= '0;
      clr_attr <= DEF_ATTR;
    end else begin
      state    <= state_nxt;
      cx       <= cx_nxt;
      cy       <= cy_nxt;
      top_row  <= top_nxt;
      clr_cnt  <= cnt_nxt;
      clr_attr <= cattr_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) attr <= DEF_ATTR;
    else if (attr_we) attr <= attr_data;
  end

  always_comb begin
    state_nxt = state;
    cx_nxt    = cx;
    cy_nxt    = cy;
    top_nxt   = top_row;
    cnt_nxt   = clr_cnt;
    cattr_nxt = clr_attr;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    newline   = 1'b0;
    tab_pos   = (8'(cx) | 8'h07) + 8'd1;
    case (state)
      CLR_ALL: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = {clr_attr, 7'h20};
        if (clr_cnt == AW'(DEPTH - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = clr_cnt + AW'(1);
      end
      CLR_LINE: begin
        // The new bottom row is the physical row just above top_row
        wr_en   = 1'b1;
        wr_addr = row_base(wrap_row(YW'(ROWS - 1), top_row)) + clr_cnt;
        wr_data = {clr_attr, 7'h20};
        if (clr_cnt == AW'(COLS - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else cnt_nxt = clr_cnt + AW'(1);
      end
      default: begin
        if (char_valid) begin
          if (char_data >= 7'h20 && char_data <= 7'h7E) begin
            wr_en   = 1'b1;
            wr_addr = row_base(wrap_row(cy, top_row)) + AW'(cx);
            wr_data = {attr, char_data};
            if (cx == XW'(COLS - 1)) newline = 1'b1;
            else cx_nxt = cx + XW'(1);
          end else begin
            case (char_data)
              7'h0D: cx_nxt = '0;
              7'h0A: newline = 1'b1;
              7'h08: if (cx != '0) cx_nxt = cx - XW'(1);
              7'h09: begin
                if (tab_pos >= 8'(COLS)) newline = 1'b1;
                else cx_nxt = XW'(tab_pos);
              end
              7'h0C: begin
                cx_nxt    = '0;
                cy_nxt    = '0;
                top_nxt   = '0;
                state_nxt = CLR_ALL;
                cnt_nxt   = '0;
                cattr_nxt = attr;
              end
              default: ;
            endcase
          end
          if (newline) begin
            cx_nxt = '0;
            if (cy != YW'(ROWS - 1)) cy_nxt = cy + YW'(1);
            else begin
              top_nxt   = (top_row == YW'(ROWS - 1)) ? '0 : top_row + YW'(1);
              state_nxt = CLR_LINE;
              cnt_nxt   = '0;
              cattr_nxt = attr;
            end
          end
        end
      end
    endcase
  end

  // Cursor blink: any accepted character restarts a full visible half-period
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (BLINK_FRAMES == 0) begin
      blink_on <= 1'b1;
    end else if (char_valid && char_ready) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_tick) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else blink_cnt <= blink_cnt + BW'(1);
    end
  end

  logic          in_range, cur_hit;
  logic [AW-1:0] rd_addr;
  logic          vis1, cur1;
  logic [2:0]    sub_x1, sub_y1;

  assign in_range = ({1'b0, pixel_x} < X_LIM) && ({1'b0, pixel_y} < Y_LIM);
  assign rd_addr  = in_range ? row_base(wrap_row(YW'(pixel_y[9:4]), top_row)) + AW'(XW'(pixel_x[9:3]))
                             : '0;
  assign cur_hit  = cursor_en && blink_on && (pixel_x[9:3] == 7'(cx)) && (pixel_y[9:4] == 6'(cy));

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    cell_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vis1   <= 1'b0;
      cur1   <= 1'b0;
      sub_x1 <= '0;
      sub_y1 <= '0;
    end else begin
      vis1   <= video_on && in_range;
      cur1   <= cur_hit;
      sub_x1 <= pixel_x[2:0];
      sub_y1 <= pixel_y[3:1];
    end
  end

  logic [63:0] g;
  logic [7:0]  font_word;
  logic [3:0]  fg, bg;
  logic        pix_bit;

  always_comb begin
    g         = glyph(cell_q[6:0]);
    font_word = g[{3'd7 - sub_y1, 3'b000} +: 8];
    pix_bit   = font_word[3'd7 - sub_x1];
    fg        = cur1 ? cell_q[14:11] : cell_q[10:7];
    bg        = cur1 ? cell_q[10:7]  : cell_q[14:11];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) text_rgb <= 8'h00;
    else text_rgb <= vis1 ? pal(pix_bit ? fg : bg) : 8'h00;
  end

endmodule
